// File: rtl/vga_pixel_feeder.sv
// Pixel feeder for VGA_Controller: buffers RGB565 pixels in a FIFO, expands them to 10-bit
// colour on request and keeps the stream aligned with controller coordinate (0,0).
module vga_pixel_feeder #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [15:0] iPix_Data,
  input  logic        iPix_Valid,
  input  logic        iPix_SOF,
  output logic        oPix_Ready,
  input  logic        iRequest,
  input  logic [9:0]  iCoord_X,
  input  logic [9:0]  iCoord_Y,
  input  logic        iClr_Err,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic        oLocked,
  output logic        oUnderflow,
  output logic        oSync_Err
);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, STREAM, RESYNC} StateT;

  StateT              state, nextState;
  logic [16:0]        fifoMem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wrPtr, rdPtr;
  logic [FIFO_AW:0]   count;
  logic               fifoEmpty, fifoFull;
  logic               pixReady, push, pop, flush;
  logic               loadOut, useHead, setUnder, setSync;
  logic               originHit;
  logic [16:0]        headEntry;
  logic [29:0]        headColour;

  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign originHit = (iCoord_X == 10'd0) && (iCoord_Y == 10'd0);
  assign headEntry = fifoMem[rdPtr];
  assign headColour = {headEntry[15:11], headEntry[15:11],
                       headEntry[10:5],  headEntry[10:7],
                       headEntry[4:0],   headEntry[4:0]};

  // Ready is forced low while reset is asserted so every output reads 0 during reset.
  assign oPix_Ready = iRST_N && pixReady;
  assign oLocked    = (state == STREAM);

  always_comb begin
    nextState = state;
    pixReady  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    loadOut   = iRequest;
    useHead   = 1'b0;
    setUnder  = 1'b0;
    setSync   = 1'b0;
    case (state)
      IDLE: begin
        pixReady = 1'b1;
        push     = iPix_Valid && iPix_SOF;
        if (push) nextState = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        pixReady = !fifoFull;
        push     = iPix_Valid && pixReady;
        if (iRequest && originHit && !fifoEmpty) begin
          pop       = 1'b1;
          useHead   = 1'b1;
          nextState = STREAM;
        end
      end
      STREAM: begin
        pixReady = !fifoFull;
        push     = iPix_Valid && pixReady;
        if (iRequest) begin
          if (fifoEmpty) begin
            setUnder  = 1'b1;
            nextState = RESYNC;
          end else begin
            pop = 1'b1;
            // A popped SOF must land exactly on the origin, and vice versa.
            if (headEntry[16] != originHit) begin
              setSync   = 1'b1;
              nextState = RESYNC;
            end else begin
              useHead = 1'b1;
            end
          end
        end
      end
      RESYNC: begin
        flush     = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= nextState;
  end

  always_ff @(posedge iCLK) begin
    if (push) fifoMem[wrPtr] <= {iPix_SOF, iPix_Data};
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
    end else if (loadOut) begin
      oRed   <= useHead ? headColour[29:20] : 10'd0;
      oGreen <= useHead ? headColour[19:10] : 10'd0;
      oBlue  <= useHead ? headColour[9:0]   : 10'd0;
    end
  end

  // Sticky flags: a new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oUnderflow <= 1'b0;
      oSync_Err  <= 1'b0;
    end else begin
      if (setUnder)      oUnderflow <= 1'b1;
      else if (iClr_Err) oUnderflow <= 1'b0;
      if (setSync)       oSync_Err  <= 1'b1;
      else if (iClr_Err) oSync_Err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed bench for vga_pixel_feeder: hand-computed colour, lock, ready and error-flag values.
module tb_vga_pixel_feeder;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [15:0] iPix_Data;
  logic        iPix_Valid;
  logic        iPix_SOF;
  logic        oPix_Ready;
  logic        iRequest;
  logic [9:0]  iCoord_X;
  logic [9:0]  iCoord_Y;
  logic        iClr_Err;
  logic [9:0]  oRed, oGreen, oBlue;
  logic        oLocked, oUnderflow, oSync_Err;

  int total = 0;
  int bad   = 0;

  vga_pixel_feeder #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iPix_Data(iPix_Data), .iPix_Valid(iPix_Valid), .iPix_SOF(iPix_SOF),
    .oPix_Ready(oPix_Ready),
    .iRequest(iRequest), .iCoord_X(iCoord_X), .iCoord_Y(iCoord_Y),
    .iClr_Err(iClr_Err),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oLocked(oLocked), .oUnderflow(oUnderflow), .oSync_Err(oSync_Err)
  );

  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic sof, input logic [15:0] data,
                               input logic req, input logic [9:0] x, input logic [9:0] y,
                               input logic clr);
    iPix_Valid = valid;
    iPix_SOF   = sof;
    iPix_Data  = data;
    iRequest   = req;
    iCoord_X   = x;
    iCoord_Y   = y;
    iClr_Err   = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkColour(input string tag, input logic [9:0] r, input logic [9:0] g,
                             input logic [9:0] b);
    checkOutput({tag, ".red"},   {22'd0, oRed},   {22'd0, r});
    checkOutput({tag, ".green"}, {22'd0, oGreen}, {22'd0, g});
    checkOutput({tag, ".blue"},  {22'd0, oBlue},  {22'd0, b});
  endtask

  initial begin
    int accepted;
    int idx;
    logic [15:0] pixData;

    iRST_N = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);
    #12;
    checkColour("reset", 10'd0, 10'd0, 10'd0);
    checkOutput("reset.ready",  {31'd0, oPix_Ready}, 32'd0);
    checkOutput("reset.locked", {31'd0, oLocked},    32'd0);
    checkOutput("reset.under",  {31'd0, oUnderflow}, 32'd0);
    checkOutput("reset.sync",   {31'd0, oSync_Err},  32'd0);
    iRST_N = 1'b1;
    #1;
    checkOutput("release.ready", {31'd0, oPix_Ready}, 32'd1);
    tick();

    // Basic stream: red, green, blue primaries
    applyStimulus(1'b1, 1'b1, 16'hF800, 1'b0, 10'd0, 10'd0, 1'b0); tick();
    applyStimulus(1'b1, 1'b0, 16'h07E0, 1'b0, 10'd0, 10'd0, 1'b0); tick();
    applyStimulus(1'b1, 1'b0, 16'h001F, 1'b0, 10'd0, 10'd0, 1'b0); tick();
    checkOutput("wait.locked", {31'd0, oLocked}, 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 10'd0, 10'd0, 1'b0); tick();
    checkColour("pix0", 10'd1023, 10'd0, 10'd0);
    checkOutput("pix0.locked", {31'd0, oLocked}, 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 10'd1, 10'd0, 1'b0); tick();
    checkColour("pix1", 10'd0, 10'd1023, 10'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 10'd2, 10'd0, 1'b0); tick();
    checkColour("pix2", 10'd0, 10'd0, 10'd1023);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 10'd3, 10'd0, 1'b0); tick();
    checkColour("hold", 10'd0, 10'd0, 10'd1023);

    // Underflow: FIFO drained, request in STREAM
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 10'd3, 10'd0, 1'b0); tick();
    checkColour("under", 10'd0, 10'd0, 10'd0);
    checkOutput("under.flag",   {31'd0, oUnderflow}, 32'd1);
    checkOutput("under.locked", {31'd0, oLocked},    32'd0);
    checkOutput("resync.ready", {31'd0, oPix_Ready}, 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0); tick();
    checkOutput("idle.ready", {31'd0, oPix_Ready}, 32'd1);

    // Non-SOF pixels in IDLE are dropped
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 16'hFFFF, 1'b0, 10'd0, 10'd0, 1'b0); tick();
    end
    applyStimulus(1'b1, 1'b1, 16'h07E0, 1'b0, 10'd0, 10'd0, 1'b0); tick();
    applyStimulus(1'b1, 1'b0, 16'hFFFF, 1'b0, 10'd0, 10'd0, 1'b0); tick();
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 10'd0, 10'd0, 1'b0); tick();
    applyStimulus(1'b1, 1'b0, 16'hF800, 1'b0, 10'd0, 10'd0, 1'b0); tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 10'd0, 10'd0, 1'b0); tick();
    checkColour("drop", 10'd0, 10'd1023, 10'd0);
    checkOutput("drop.sync", {31'd0, oSync_Err}, 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 10'd1, 10'd0, 1'b0); tick();
    checkColour("white", 10'd1023, 10'd1023, 10'd1023);

    // SOF popped at (37,4): sync error, flush
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 10'd37, 10'd4, 1'b0); tick();
    checkColour("syncerr", 10'd0, 10'd0, 10'd0);
    checkOutput("syncerr.flag",   {31'd0, oSync_Err}, 32'd1);
    checkOutput("syncerr.locked", {31'd0, oLocked},   32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0); tick();
    applyStimulus(1'b1, 1'b1, 16'h8410, 1'b0, 10'd0, 10'd0, 1'b0); tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 10'd0, 10'd0, 1'b0); tick();
    checkColour("relock", 10'd528, 10'd520, 10'd528);
    checkOutput("relock.locked", {31'd0, oLocked},   32'd1);
    checkOutput("relock.sync",   {31'd0, oSync_Err}, 32'd1);

    // Clear flags, then clear coinciding with a fresh underflow
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b1); tick();
    checkOutput("clr.under", {31'd0, oUnderflow}, 32'd0);
    checkOutput("clr.sync",  {31'd0, oSync_Err},  32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 10'd1, 10'd0, 1'b1); tick();
    checkOutput("setwins.under", {31'd0, oUnderflow}, 32'd1);
    checkColour("setwins", 10'd0, 10'd0, 10'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0); tick();

    // Fill FIFO while stalled in WAIT_FRAME: 20 cycles offered, 16 accepted
    accepted = 0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      pixData = (idx == 0) ? 16'h001F : ((idx == 1) ? 16'hF800 : 16'h07E0);
      applyStimulus(1'b1, (idx == 0), pixData, 1'b0, 10'd0, 10'd0, 1'b0);
      #1;
      if (oPix_Ready) begin
        accepted++;
        idx++;
      end
      tick();
    end
    checkOutput("full.accepted", accepted, 32'd16);
    checkOutput("full.ready", {31'd0, oPix_Ready}, 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 10'd5, 10'd5, 1'b0); tick();
    checkColour("waitblack", 10'd0, 10'd0, 10'd0);
    checkOutput("waitblack.ready", {31'd0, oPix_Ready}, 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 10'd0, 10'd0, 1'b0); tick();
    checkColour("fullpop", 10'd0, 10'd0, 10'd1023);
    checkOutput("fullpop.ready", {31'd0, oPix_Ready}, 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 10'd1, 10'd0, 1'b0); tick();
    checkColour("fullpop2", 10'd1023, 10'd0, 10'd0);

    // Asynchronous reset mid-frame
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);
    #2;
    iRST_N = 1'b0;
    #1;
    checkColour("midreset", 10'd0, 10'd0, 10'd0);
    checkOutput("midreset.locked", {31'd0, oLocked},    32'd0);
    checkOutput("midreset.under",  {31'd0, oUnderflow}, 32'd0);
    #10;
    iRST_N = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b1, 16'h07E0, 1'b0, 10'd0, 10'd0, 1'b0); tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 10'd0, 10'd0, 1'b0); tick();
    checkColour("postreset", 10'd0, 10'd1023, 10'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 10'd1, 10'd0, 1'b0); tick();
    checkOutput("postreset.empty", {31'd0, oUnderflow}, 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pixel_feeder.md
Name: vga_pixel_feeder

Overview:
- Upstream neighbour of VGA_Controller: buffers an RGB565 pixel stream from the frame-buffer read path in a small FIFO.
- Pops one pixel per iRequest and drives the controller's 10-bit iRed/iGreen/iBlue inputs.
- Aligns stream start-of-frame with controller coordinate (0,0).
- Detects underflow and frame misalignment, then recovers by resynchronising at the next frame.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 4.
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- iCLK  in  1  pixel clock, same clock as VGA_Controller.
- iRST_N  in  1  reset; asynchronous, active-low.
- iPix_Data  in  16  RGB565 pixel: [15:11] R, [10:5] G, [4:0] B.
- iPix_Valid  in  1  upstream pixel valid.
- iPix_SOF  in  1  marks the first pixel of a frame; qualified by iPix_Valid.
- oPix_Ready  out  1  feeder accepts a pixel this cycle; transfer when iPix_Valid & oPix_Ready.
- iRequest  in  1  controller pixel request (oRequest of VGA_Controller).
- iCoord_X  in  10  controller X coordinate, valid with iRequest.
- iCoord_Y  in  10  controller Y coordinate, valid with iRequest.
- iClr_Err  in  1  clears sticky error flags.
- oRed  out  10  expanded red to controller.
- oGreen  out  10  expanded green.
- oBlue  out  10  expanded blue.
- oLocked  out  1  high while in STREAM.
- oUnderflow  out  1  sticky: request while FIFO empty in STREAM.
- oSync_Err  out  1  sticky: SOF/coordinate mismatch in STREAM.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE. oPix_Ready is 1 in IDLE, so it is 1 immediately after reset release.
- FIFO:
  - 17-bit entries {SOF, RGB565}.
  - Push on accepted transfer; pop only as defined below.
  - Simultaneous push and pop keeps count unchanged.
  - No bypass: a push into an empty FIFO is not poppable in the same cycle.
- oPix_Ready: 1 in IDLE; !full in WAIT_FRAME and STREAM; 0 in RESYNC. Derived from registered count.
- Colour expansion:
  - R10 = {R5,R5}
  - G10 = {G6,G6[5:2]}
  - B10 = {B5,B5}
  - Black = all zero.
- Output timing: oRed/oGreen/oBlue are registered and update the cycle after iRequest (1-cycle latency). They hold their value when iRequest is low.
- State IDLE:
  - Accepted non-SOF pixels are discarded and not written.
  - An accepted SOF pixel is written; go to WAIT_FRAME.
  - Requests output black.
- State WAIT_FRAME:
  - FIFO fills normally.
  - iRequest with coord (0,0): pop the head (guaranteed SOF); go to STREAM.
  - Any other request outputs black without a pop.
- State STREAM:
  - Each iRequest pops one entry and outputs its colour.
  - Request with FIFO empty: output black, set oUnderflow, go to RESYNC.
  - Popped entry SOF=1 but coord != (0,0), or SOF=0 but coord == (0,0): output black, set oSync_Err, go to RESYNC.
- State RESYNC: one cycle; flush FIFO (count=0); outputs black; go to IDLE.
- oLocked = (state == STREAM), registered.
- Sticky flags:
  - Set and clear in the same cycle: set wins.
  - iClr_Err clears both flags otherwise.
- Asynchronous reset mid-frame returns to IDLE and discards FIFO contents.
- Pointers wrap modulo FIFO_DEPTH. Count is FIFO_AW+1 bits, so full = (count == FIFO_DEPTH).

Test Plan:
- Reset release, then stream SOF pixel 0xF800 followed by 0x07E0, 0x001F; controller request at (0,0),(1,0),(2,0) -> outputs one cycle later: (1023,0,0), (0,1023,0), (0,0,1023); oLocked=1 the cycle after the first pop.
- Upstream sends 5 non-SOF pixels before SOF in IDLE -> none stored; the first popped pixel is the SOF pixel; oSync_Err=0.
- FIFO_DEPTH=16 with requests stalled in WAIT_FRAME and 20 pixels offered -> exactly 16 accepted; oPix_Ready=0 while full; returns to 1 the cycle after the first pop.
- In STREAM, stop upstream until the FIFO is empty, then issue a request -> black output, oUnderflow=1, one RESYNC cycle, then IDLE with oPix_Ready=1 and oLocked=0.
- In STREAM, insert a SOF pixel that is popped at coord (37,4) -> black, oSync_Err=1, FIFO flushed; relock on the next SOF at (0,0).
- Assert iClr_Err while a new underflow occurs in the same cycle -> oUnderflow stays 1. Assert iRST_N=0 mid-frame -> all outputs 0 asynchronously; FIFO empty after release.
